// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state type, NOP encoding and default queue depth for the fetch unit
package fetch_pkg;
    typedef enum logic {RUN, DISCARD} fetch_state_e;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int DEFAULT_DEPTH = 2;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small FIFO with synchronous flush and occupancy count
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W = 64,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
    assign dout = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: in-order instruction fetch with pending-PC list, instruction queue and flush discard
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = DEFAULT_DEPTH,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    output logic        pc_stall_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [31:0] unused_reset_pc = RESET_PC;
    fetch_state_e state, state_nx;
    logic [CW-1:0] occ, outs, dcnt, dcnt_nx;
    logic [63:0] head;
    logic [31:0] pend_pc;
    logic [1:0] unused_pc_lsb;
    logic grant, rsp_run, pop;
    assign unused_pc_lsb = pc_i[1:0];
    assign imem_addr_o = {pc_i[31:2], 2'b00};
    assign imem_req_o = rst && state == RUN && !flush_i &&
                        (CW+1)'(occ) + (CW+1)'(outs) < (CW+1)'(DEPTH);
    assign grant = imem_req_o && imem_gnt_i;
    assign pc_stall_o = !grant;
    assign rsp_run = state == RUN && imem_rvalid_i && !flush_i;
    assign instr_valid_o = occ != '0;
    assign pop = instr_valid_o && instr_ready_i;
    assign instr_o = instr_valid_o ? head[31:0] : NOP;
    assign instr_pc_o = instr_valid_o ? head[63:32] : '0;
    fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_pend (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (rsp_run),
        .flush (flush_i),
        .din   (imem_addr_o),
        .dout  (pend_pc),
        .count (outs)
    );
    fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_run),
        .pop   (pop),
        .flush (flush_i),
        .din   ({pend_pc, imem_rdata_i}),
        .dout  (head),
        .count (occ)
    );
    // a flush turns every still-outstanding request into one to be dropped
    always_comb begin
        dcnt_nx  = state == RUN ? (flush_i ? outs - CW'(imem_rvalid_i) : '0)
                                : dcnt - CW'(imem_rvalid_i);
        state_nx = dcnt_nx != '0 ? DISCARD : RUN;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            dcnt  <= '0;
        end else begin
            state <= state_nx;
            dcnt  <= dcnt_nx;
        end
    end
endmodule
